apb_crc_slave: RTL and testbench

APB_CRC_SLAVE -- requirements
Module: apb_crc_slave

---
 rtl/apb_crc_slave_if.sv | 26 ++
 rtl/apb_crc_slave.sv | 195 +++++++++++++++++++
 tb/tb_apb_crc_slave.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_crc_slave_if.sv
// rtl/apb_crc_slave_if.sv - APB bus bundle for the CRC-32 slave
interface apb_crc_slave_if #(
    parameter int ADDR = 32,
    parameter int DATA = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR-1:0]   paddr;
    logic [DATA-1:0]   pwdata;
    logic [DATA/4-1:0] pstrobe;
    logic [2:0]        pprot;
    logic              pready;
    logic [DATA-1:0]   prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrobe, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrobe, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_crc_slave.sv
// rtl/apb_crc_slave.sv - APB slave computing CRC-32 one byte per clock over DATA_IN writes
// Define APB_CRC_SLVERR_EN to return pslverr on unmapped or wrong-direction accesses.
module apb_crc_slave #(
    parameter int ADDR = 32,
    parameter int DATA = 32
) (
    input  logic           system_clock,
    input  logic           reset,
    apb_crc_slave_if.slave apb
);
    localparam logic [31:0] POLY       = 32'hEDB8_8320;
    localparam logic [7:0]  OFF_CTRL   = 8'h00;
    localparam logic [7:0]  OFF_DATA   = 8'h04;
    localparam logic [7:0]  OFF_CRC    = 8'h08;
    localparam logic [7:0]  OFF_STATUS = 8'h0C;
    localparam logic [7:0]  OFF_INIT   = 8'h10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CRC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] init_q, init_d;
    logic [31:0] data_q, data_d;
    logic [15:0] count_q, count_d;
    logic [3:0]  lanes_q, lanes_d;
    logic        abort_q, abort_d;

    logic        access;
    logic [7:0]  off;
    logic [3:0]  strb;
    logic        is_ctrl, is_data, is_crc, is_status, is_init;
    logic        start;
    logic        bad_access;
    logic        err_resp;
    logic [1:0]  lane_in, lane_crc;
    logic [3:0]  rest;
    logic        proc;
    logic [7:0]  proc_byte;
    logic        unused_bits;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h00_0000, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [1:0] first_lane(input logic [3:0] m);
        logic [1:0] l;
        l = 2'd3;
        if (m[2]) l = 2'd2;
        if (m[1]) l = 2'd1;
        if (m[0]) l = 2'd0;
        return l;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] l);
        return d[{l, 3'b000} +: 8];
    endfunction

    assign access    = apb.psel & apb.penable;
    assign off       = apb.paddr[7:0];
    assign strb      = apb.pstrobe[3:0];
    assign is_ctrl   = (off == OFF_CTRL);
    assign is_data   = (off == OFF_DATA);
    assign is_crc    = (off == OFF_CRC);
    assign is_status = (off == OFF_STATUS);
    assign is_init   = (off == OFF_INIT);
    assign lane_in   = first_lane(strb);
    assign lane_crc  = first_lane(lanes_q);
    assign rest      = strb & ~(4'b0001 << lane_in);
    assign start     = (state_q == S_IDLE) && access && apb.pwrite && is_data && (strb != 4'b0000);
    assign bad_access = apb.pwrite ? !(is_ctrl | is_data | is_init)
                                   : !(is_crc | is_status | is_init);

`ifdef APB_CRC_SLVERR_EN
    assign err_resp    = bad_access;
    assign unused_bits = ^{apb.pprot, apb.paddr[ADDR-1:8], apb.pstrobe[DATA/4-1:4]};
`else
    assign err_resp    = 1'b0;
    assign unused_bits = ^{apb.pprot, apb.paddr[ADDR-1:8], apb.pstrobe[DATA/4-1:4], bad_access};
`endif

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The capture edge already folds in the first lane, so N lanes cost N+1 access cycles.
    always_comb begin
        state_d = state_q;
        lanes_d = lanes_q;
        data_d  = data_q;
        abort_d = abort_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = apb.pwdata[31:0];
                    lanes_d = rest;
                    abort_d = 1'b0;
                    state_d = (rest != 4'b0000) ? S_CRC : S_DONE;
                end
            end
            S_CRC: begin
                lanes_d = lanes_q & ~(4'b0001 << lane_crc);
                abort_d = abort_q | ~apb.psel;
                if (lanes_d == 4'b0000) begin
                    state_d = abort_d ? S_IDLE : S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        apb.pready  = 1'b0;
        apb.prdata  = '0;
        apb.pslverr = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    if (access && !start) begin
                        apb.pready  = 1'b1;
                        apb.pslverr = err_resp;
                        if (!apb.pwrite) begin
                            if (is_crc)         apb.prdata = ~crc_q;
                            else if (is_status) apb.prdata = {16'h0000, count_q};
                            else if (is_init)   apb.prdata = init_q;
                        end
                    end
                end
                S_DONE:  apb.pready = 1'b1;
                default: apb.pready = 1'b0;
            endcase
        end
    end

    always_comb begin
        crc_d     = crc_q;
        init_d    = init_q;
        count_d   = count_q;
        proc      = 1'b0;
        proc_byte = 8'h00;
        if (start) begin
            proc      = 1'b1;
            proc_byte = lane_byte(apb.pwdata[31:0], lane_in);
        end else if ((state_q == S_CRC) && (lanes_q != 4'b0000)) begin
            proc      = 1'b1;
            proc_byte = lane_byte(data_q, lane_crc);
        end
        if ((state_q == S_IDLE) && access && apb.pwrite) begin
            if (is_ctrl && apb.pwdata[0]) begin
                crc_d   = init_q;
                count_d = 16'h0000;
            end
            if (is_init) begin
                for (int i = 0; i < 4; i++) begin
                    if (strb[i]) init_d[8*i +: 8] = apb.pwdata[8*i +: 8];
                end
            end
        end
        if (proc) begin
            crc_d   = crc_byte(crc_q, proc_byte);
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            crc_q   <= 32'hFFFF_FFFF;
            init_q  <= 32'hFFFF_FFFF;
            count_q <= 16'h0000;
            data_q  <= 32'h0000_0000;
            lanes_q <= 4'b0000;
            abort_q <= 1'b0;
        end else begin
            crc_q   <= crc_d;
            init_q  <= init_d;
            count_q <= count_d;
            data_q  <= data_d;
            lanes_q <= lanes_d;
            abort_q <= abort_d;
        end
    end
endmodule

// File: tb/tb_apb_crc_slave.sv
// tb/tb_apb_crc_slave.sv - directed scoreboard bench for apb_crc_slave
module tb_apb_crc_slave;
    logic system_clock = 1'b0;
    logic reset;

    apb_crc_slave_if #(.ADDR(32), .DATA(32)) bus ();

    apb_crc_slave #(.ADDR(32), .DATA(32)) dut (
        .system_clock(system_clock),
        .reset       (reset),
        .apb         (bus)
    );

    always #5 system_clock = ~system_clock;

`ifdef APB_CRC_SLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          tests  = 0;
    int          failed = 0;
    logic [31:0] crc_m, init_m;
    logic [15:0] cnt_m;
    logic        saw;

    function automatic logic [31:0] model_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        case (addr[7:0])
            8'h00: if (d[0]) begin crc_m = init_m; cnt_m = 16'h0; end
            8'h04: for (int l = 0; l < 4; l++) if (s[l]) begin
                       crc_m = model_byte(crc_m, d[8*l +: 8]);
                       cnt_m = cnt_m + 16'd1;
                   end
            8'h10: for (int l = 0; l < 4; l++) if (s[l]) init_m[8*l +: 8] = d[8*l +: 8];
            default: ;
        endcase
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_next(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
            return;
        end
        e = sb.pop_front();
        tests++;
        assert (obs === e.val) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int cyc);
        @(negedge system_clock);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        bus.pstrobe = {4'hA, strb};
        bus.pprot   = 3'b010;
        @(negedge system_clock);
        bus.penable = 1'b1;
        cyc = 1;
        #1;
        while (bus.pready !== 1'b1 && cyc < 32) begin
            @(negedge system_clock);
            cyc++;
            #1;
        end
        rdata = bus.prdata;
        err   = bus.pslverr;
        @(posedge system_clock);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] d,
                            input logic [3:0] s, input int exp_cyc, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        expect_val({tag, "_cycles"}, exp_cyc);
        expect_val({tag, "_pslverr"}, {31'h0, exp_err});
        apb_xfer(1'b1, addr, d, s, rd, er, cyc);
        check_next(cyc);
        check_next({31'h0, er});
        model_write(addr, d, s);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_d,
                           input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        expect_val({tag, "_cycles"}, 32'd1);
        expect_val({tag, "_prdata"}, exp_d);
        expect_val({tag, "_pslverr"}, {31'h0, exp_err});
        apb_xfer(1'b0, addr, 32'h0, 4'h0, rd, er, cyc);
        check_next(cyc);
        check_next(rd);
        check_next({31'h0, er});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h10;
        bus.pwdata  = 32'h0;
        bus.pstrobe = 8'h0F;
        bus.pprot   = 3'b000;
        crc_m  = 32'hFFFF_FFFF;
        init_m = 32'hFFFF_FFFF;
        cnt_m  = 16'h0;

        // Outputs must stay quiet under reset even with an access on the bus.
        repeat (3) @(negedge system_clock);
        #1;
        expect_val("rst_pready", 32'h0);   check_next({31'h0, bus.pready});
        expect_val("rst_prdata", 32'h0);   check_next(bus.prdata);
        expect_val("rst_pslverr", 32'h0);  check_next({31'h0, bus.pslverr});
        @(negedge system_clock);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        reset       = 1'b0;

        do_read("rst_init",    32'h10, 32'hFFFF_FFFF, 1'b0);
        do_read("rst_status",  32'h0C, 32'h0, 1'b0);
        do_read("rst_crc_out", 32'h08, 32'h0, 1'b0);

        do_write("ctrl_init0", 32'h00, 32'h1, 4'hF, 1, 1'b0);
        do_write("data_1234",  32'h04, 32'h3433_3231, 4'hF, 5, 1'b0);
        do_write("data_5678",  32'h04, 32'h3837_3635, 4'hF, 5, 1'b0);
        do_write("data_9",     32'h04, 32'h0000_0039, 4'h1, 2, 1'b0);
        do_read("check_crc",    32'h08, 32'hCBF4_3926, 1'b0);
        do_read("check_status", 32'h0C, 32'h0000_0009, 1'b0);

        do_write("strb_1111", 32'h04, 32'hDEAD_BEEF, 4'hF, 5, 1'b0);
        do_write("strb_0101", 32'h04, 32'h0102_0304, 4'h5, 3, 1'b0);
        do_write("strb_0000", 32'h04, 32'hFFFF_FFFF, 4'h0, 1, 1'b0);
        do_read("crc_after_strobes",    32'h08, ~crc_m, 1'b0);
        do_read("status_after_strobes", 32'h0C, 32'd15, 1'b0);

        do_read("rd_ctrl",    32'h00, 32'h0, ERR_EN);
        do_read("rd_data_in", 32'h04, 32'h0, ERR_EN);
        do_write("wr_crc_out", 32'h08, 32'h1234_5678, 4'hF, 1, ERR_EN);
        do_write("wr_status",  32'h0C, 32'hFFFF_FFFF, 4'hF, 1, ERR_EN);
        do_read("crc_unchanged",    32'h08, ~crc_m, 1'b0);
        do_read("status_unchanged", 32'h0C, 32'd15, 1'b0);

        do_write("init_zero", 32'h10, 32'h0, 4'hF, 1, 1'b0);
        do_write("ctrl_init1", 32'h00, 32'h1, 4'hF, 1, 1'b0);
        do_read("crc_from_init0",  32'h08, 32'hFFFF_FFFF, 1'b0);
        do_read("init_readback",   32'h10, 32'h0, 1'b0);
        do_read("status_cleared",  32'h0C, 32'h0, 1'b0);
        do_read("init_upper_addr", 32'hABCD_0010, 32'h0, 1'b0);
        do_read("unmapped_0x20",   32'h20, 32'h0, ERR_EN);

        // Reset lands two access cycles into a four-lane DATA_IN write.
        saw = 1'b0;
        @(negedge system_clock);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h04;
        bus.pwdata  = 32'h1122_3344;
        bus.pstrobe = 8'h0F;
        @(negedge system_clock);
        bus.penable = 1'b1;
        #1 saw = saw | bus.pready;
        @(negedge system_clock);
        #1 saw = saw | bus.pready;
        @(negedge system_clock);
        reset = 1'b1;
        #1 saw = saw | bus.pready;
        repeat (2) begin
            @(negedge system_clock);
            #1 saw = saw | bus.pready;
        end
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(negedge system_clock);
        reset = 1'b0;
        #1 saw = saw | bus.pready;
        @(negedge system_clock);
        #1 saw = saw | bus.pready;
        expect_val("reset_no_pready", 32'h0);
        check_next({31'h0, saw});
        crc_m  = 32'hFFFF_FFFF;
        init_m = 32'hFFFF_FFFF;
        cnt_m  = 16'h0;
        do_read("rst2_crc_out", 32'h08, 32'h0, 1'b0);
        do_read("rst2_status",  32'h0C, 32'h0, 1'b0);
        do_read("rst2_init",    32'h10, 32'hFFFF_FFFF, 1'b0);

        // Fast preload: psel is dropped right after capture, so the slave finishes the
        // word without a DONE cycle and is back in IDLE four clocks later.
        saw = 1'b0;
        for (int i = 0; i < 16383; i++) begin
            @(negedge system_clock);
            bus.psel    = 1'b1;
            bus.penable = 1'b1;
            bus.pwrite  = 1'b1;
            bus.paddr   = 32'h04;
            bus.pwdata  = $urandom;
            bus.pstrobe = 8'h0F;
            #1 saw = saw | bus.pready;
            repeat (3) begin
                @(negedge system_clock);
                bus.psel    = 1'b0;
                bus.penable = 1'b0;
                #1 saw = saw | bus.pready;
            end
        end
        expect_val("abort_no_pready", 32'h0);
        check_next({31'h0, saw});
        do_read("status_fffc", 32'h0C, 32'h0000_FFFC, 1'b0);
        do_write("two_bytes_a", 32'h04, 32'h0000_AA55, 4'h3, 3, 1'b0);
        do_read("status_fffe", 32'h0C, 32'h0000_FFFE, 1'b0);
        do_write("two_bytes_b", 32'h04, 32'h0000_1234, 4'h3, 3, 1'b0);
        do_read("status_wrap", 32'h0C, 32'h0000_0000, 1'b0);

        if (sb.size() != 0) begin
            tests++;
            failed++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
